// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch button path.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      PRESSED      = 3'd2,
      HELD         = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;     // 10 ms at 50 MHz
   localparam int unsigned DEF_HOLD_CYCLES     = 100000000;  // 2 s at 50 MHz

   // One spare bit above the largest terminal count keeps the compare headroom.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return 32'($clog2(m)) + 32'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_debounce_pulse.sv
// Start/stop button conditioner: sync, press/release debounce, press/release/long pulses.
module button_debounce_pulse
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic btn_level
);

   localparam int unsigned   CW        = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

   logic          w_btn_in;
   logic          w_btn_s;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_press;
   logic          r_release;
   logic          r_long;
   logic          r_level;

   assign w_btn_in = btn_raw ^ BTN_ACTIVE_LOW;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (w_btn_in),
      .o_q   (w_btn_s)
   );

   // Counter restarts on every state entry, so it never needs to wrap.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_level   <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_btn_s) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!w_btn_s) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state <= PRESSED;
                  r_press <= 1'b1;
                  r_level <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (!w_btn_s) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= CW'(1);
               end else if (r_cnt == HOLD_LAST) begin
                  r_state <= HELD;
                  r_long  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            HELD: begin
               if (!w_btn_s) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= CW'(1);
               end
            end
            RELEASE_WAIT: begin
               // A bounce back high parks in HELD: no second press, no long detect.
               if (w_btn_s) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state   <= IDLE;
                  r_release <= 1'b1;
                  r_level   <= 1'b0;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign long_pulse    = r_long;
   assign btn_level     = r_level;

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Conditions the raw start/stop pushbutton for the stopwatch.
- Synchronises the button into clk, debounces press and release, and emits single-cycle event pulses.
- press_pulse drives the data (toggle-enable) input of the run/stop T flip-flop directly downstream; one clean press produces exactly one toggle.
- long_pulse (hold detect) drives the stopwatch clear path.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a press or a release (10 ms at 50 MHz). Must be >= 2.
- HOLD_CYCLES, 100000000: cycles held after an accepted press before long_pulse fires (2 s at 50 MHz). Must be >= 2.
- BTN_ACTIVE_LOW, 0: 1 means btn_raw is inverted before synchronisation.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset. Sampled on posedge clk; 0 = reset.
- btn_raw  input  1  asynchronous pushbutton level.
- press_pulse  output  1  one-cycle pulse per accepted press; feeds the TFF data input.
- release_pulse  output  1  one-cycle pulse per accepted release.
- long_pulse  output  1  one-cycle pulse when a press has been held HOLD_CYCLES.
- btn_level  output  1  debounced button level.

Behaviour:
- Reset (reset==0 at posedge): sync FFs=0, state=IDLE, cnt=0, all outputs=0. Reset overrides everything, including mid-press.
- After reset deasserts with the button still held, the press is re-debounced and produces a fresh press_pulse.
- Synchroniser: btn_in = btn_raw ^ BTN_ACTIVE_LOW, passed through 2 FFs to give btn_s (2-cycle latency).
- All outputs are registered. The pulse outputs default to 0 every cycle.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES)) + 1 bits, unsigned. The counter never wraps; it is reset on every state entry.
- IDLE:
  - btn_s=1 -> PRESS_WAIT, cnt=1.
- PRESS_WAIT:
  - btn_s=0 -> IDLE (bounce rejected; no pulse).
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press_pulse=1, btn_level=1, cnt=0.
  - Otherwise cnt++.
- PRESSED:
  - btn_s=0 -> RELEASE_WAIT, cnt=1.
  - btn_s=1 and cnt==HOLD_CYCLES-1 -> HELD, long_pulse=1.
  - Otherwise cnt++.
- HELD:
  - btn_s=0 -> RELEASE_WAIT, cnt=1.
  - No further long_pulse while in HELD.
- RELEASE_WAIT:
  - btn_s=1 -> HELD, cnt=0. A release bounce cancels any pending long-press detection for this press and never re-emits press_pulse.
  - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1, btn_level=0.
  - Otherwise cnt++.
- btn_level is 1 in PRESSED, HELD and RELEASE_WAIT; 0 otherwise.
- Latency: with btn_raw high before edge E0 and held stable, press_pulse is high for the one cycle following edge E0+DEBOUNCE_CYCLES+1.
- At most one of the pulse outputs is high in any cycle. press_pulse and release_pulse strictly alternate.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum (IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT), 3-bit encoding.
  - Default cycle constants for 50 MHz.
  - Counter width function.
- One sub-module: sync_2ff (1-bit two-flop synchroniser, same clk and synchronous active-low reset), instantiated once.
- FSM and counter live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, BTN_ACTIVE_LOW=0):
1. Reset: hold reset=0 for 3 cycles with btn_raw=1 -> all outputs 0 and state IDLE. Release reset, keep btn_raw=1 -> press_pulse=1 exactly 5 edges after the first sampled high.
2. Clean press: btn_raw 0->1 before edge E0, held 8 cycles -> single press_pulse in the cycle after E0+5; btn_level=1 from that cycle; no long_pulse.
3. Bounce rejection: btn_raw pattern 1,1,0,1,1,0 (one cycle each) then 0 -> no press_pulse, btn_level stays 0. Follow with 1 held for 6 cycles -> exactly one press_pulse.
4. Long press: btn_raw held 20 cycles -> press_pulse at E0+5, long_pulse 10 cycles later, no second long_pulse. Release for 6 cycles -> release_pulse 5 edges after release, btn_level=0.
5. Release bounce: short press, then release pattern 0,0,1,0 then steady 0 -> one release_pulse only, no extra press_pulse, no long_pulse.
6. Reset mid-hold: assert reset=0 for 1 cycle while in HELD -> outputs 0 next cycle. With the button still held, exactly one new press_pulse follows after re-debounce.
